// File: rtl/dvi_pixel_prep.sv
// Two-stage colour/sync preparation for dvi_encoder_top plus per-line / per-frame measurement.
// Define DVI_TEST_PATTERN_EN to add the tp_en port and the vertical colour-bar generator.
module dvi_pixel_prep #(
    parameter bit HSYNC_ACTIVE_LOW = 1'b0,
    parameter bit VSYNC_ACTIVE_LOW = 1'b0,
    parameter int HW               = 11,
    parameter int VW               = 10
) (
    input  logic          clk_dot4x,
    input  logic          rst_n,
    input  logic [5:0]    red_in,
    input  logic [5:0]    green_in,
    input  logic [5:0]    blue_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          active_in,
`ifdef DVI_TEST_PATTERN_EN
    input  logic          tp_en,
`endif
    output logic [7:0]    red_out,
    output logic [7:0]    green_out,
    output logic [7:0]    blue_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          de_out,
    output logic [HW-1:0] h_count_out,
    output logic [VW-1:0] v_count_out,
    output logic          frame_tick
);

    typedef logic [63:0][7:0] lut_t;

    function automatic lut_t build_scale_lut();
        lut_t lut;
        for (int i = 0; i < 64; i++) begin
            lut[i] = 8'((i * 255) / 63);
        end
        return lut;
    endfunction

    localparam lut_t SCALE_LUT = build_scale_lut();

`ifdef DVI_TEST_PATTERN_EN
    // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction
`endif

    // S1: raw input capture
    logic [5:0]    red_s1_q, red_s1_d;
    logic [5:0]    green_s1_q, green_s1_d;
    logic [5:0]    blue_s1_q, blue_s1_d;
    logic          hs_s1_q, hs_s1_d;
    logic          vs_s1_q, vs_s1_d;
    logic          act_s1_q, act_s1_d;

    // S2: output registers; hs/vs/de also serve as the previous S1 value for edge detection
    logic [7:0]    red_q, red_d;
    logic [7:0]    green_q, green_d;
    logic [7:0]    blue_q, blue_d;
    logic          hs_s2_q, hs_s2_d;
    logic          vs_s2_q, vs_s2_d;
    logic          de_q, de_d;
    logic          frame_tick_q, frame_tick_d;

    // Measurement state
    logic [HW-1:0] pix_cnt_q, pix_cnt_d;
    logic [HW-1:0] h_count_q, h_count_d;
    logic [VW-1:0] line_cnt_q, line_cnt_d;
    logic [VW-1:0] v_count_q, v_count_d;

    logic          hs_rise, vs_rise, act_rise, act_fall;

`ifdef DVI_TEST_PATTERN_EN
    logic          tp_s1_q, tp_s1_d;
    logic          tp_on_q, tp_on_d;
    logic [2:0]    bar_idx;
`endif

    always_comb begin
        hs_rise    = hs_s1_q & ~hs_s2_q;
        vs_rise    = vs_s1_q & ~vs_s2_q;
        act_rise   = act_s1_q & ~de_q;
        act_fall   = ~act_s1_q & de_q;

        red_s1_d   = red_in;
        green_s1_d = green_in;
        blue_s1_d  = blue_in;
        hs_s1_d    = hsync_in;
        vs_s1_d    = vsync_in;
        act_s1_d   = active_in;

        hs_s2_d      = hs_s1_q;
        vs_s2_d      = vs_s1_q;
        de_d         = act_s1_q;
        frame_tick_d = vs_rise;

        red_d   = 8'h00;
        green_d = 8'h00;
        blue_d  = 8'h00;
        if (act_s1_q) begin
            red_d   = SCALE_LUT[red_s1_q];
            green_d = SCALE_LUT[green_s1_q];
            blue_d  = SCALE_LUT[blue_s1_q];
        end

`ifdef DVI_TEST_PATTERN_EN
        tp_s1_d = tp_en;
        tp_on_d = vs_rise ? tp_s1_q : tp_on_q;
        // Position of the pixel now in S1: the counter only reaches it on the next edge.
        bar_idx = act_rise ? 3'd0 : pix_cnt_q[7:5];
        if (act_s1_q && tp_on_q) begin
            {red_d, green_d, blue_d} = bar_rgb(bar_idx);
        end
`endif

        pix_cnt_d = pix_cnt_q;
        h_count_d = h_count_q;
        if (act_rise) begin
            pix_cnt_d = HW'(1);
        end else if (act_s1_q && (pix_cnt_q != '1)) begin
            pix_cnt_d = pix_cnt_q + HW'(1);
        end
        if (act_fall) begin
            h_count_d = pix_cnt_q;
        end

        line_cnt_d = line_cnt_q;
        v_count_d  = v_count_q;
        if (hs_rise && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + VW'(1);
        end
        // A line starting on the vsync edge belongs to the new frame.
        if (vs_rise) begin
            v_count_d  = line_cnt_q;
            line_cnt_d = hs_rise ? VW'(1) : '0;
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            red_s1_q     <= '0;
            green_s1_q   <= '0;
            blue_s1_q    <= '0;
            hs_s1_q      <= 1'b0;
            vs_s1_q      <= 1'b0;
            act_s1_q     <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            hs_s2_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            de_q         <= 1'b0;
            frame_tick_q <= 1'b0;
            pix_cnt_q    <= '0;
            h_count_q    <= '0;
            line_cnt_q   <= '0;
            v_count_q    <= '0;
`ifdef DVI_TEST_PATTERN_EN
            tp_s1_q      <= 1'b0;
            tp_on_q      <= 1'b0;
`endif
        end else begin
            red_s1_q     <= red_s1_d;
            green_s1_q   <= green_s1_d;
            blue_s1_q    <= blue_s1_d;
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            act_s1_q     <= act_s1_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            hs_s2_q      <= hs_s2_d;
            vs_s2_q      <= vs_s2_d;
            de_q         <= de_d;
            frame_tick_q <= frame_tick_d;
            pix_cnt_q    <= pix_cnt_d;
            h_count_q    <= h_count_d;
            line_cnt_q   <= line_cnt_d;
            v_count_q    <= v_count_d;
`ifdef DVI_TEST_PATTERN_EN
            tp_s1_q      <= tp_s1_d;
            tp_on_q      <= tp_on_d;
`endif
        end
    end

    assign red_out     = red_q;
    assign green_out   = green_q;
    assign blue_out    = blue_q;
    assign hsync_out   = hs_s2_q ^ HSYNC_ACTIVE_LOW;
    assign vsync_out   = vs_s2_q ^ VSYNC_ACTIVE_LOW;
    assign de_out      = de_q;
    assign frame_tick  = frame_tick_q;
    assign h_count_out = h_count_q;
    assign v_count_out = v_count_q;

endmodule

// File: tb/tb_dvi_pixel_prep.sv
// Bench for dvi_pixel_prep: constant vector table, directed frame sequences and a random run
// checked every cycle against a sample-stream reference model.
module tb_dvi_pixel_prep;
    localparam int HW   = 11;
    localparam int VW   = 10;
    localparam int HMAX = (1 << HW) - 1;
    localparam int VMAX = (1 << VW) - 1;
`ifdef DVI_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] red_i = '0, green_i = '0, blue_i = '0;
    logic hs_i = 1'b0, vs_i = 1'b0, act_i = 1'b0, tp_i = 1'b0;

    logic [7:0] red_o, green_o, blue_o, i_red, i_green, i_blue;
    logic hs_o, vs_o, de_o, tick_o, i_hs, i_vs, i_de, i_tick;
    logic [HW-1:0] h_o, i_h;
    logic [VW-1:0] v_o, i_v;

    always #5 clk = ~clk;

    dvi_pixel_prep #(.HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0), .HW(HW), .VW(VW)) dut (
        .clk_dot4x(clk), .rst_n(rst_n),
        .red_in(red_i), .green_in(green_i), .blue_in(blue_i),
        .hsync_in(hs_i), .vsync_in(vs_i), .active_in(act_i),
`ifdef DVI_TEST_PATTERN_EN
        .tp_en(tp_i),
`endif
        .red_out(red_o), .green_out(green_o), .blue_out(blue_o),
        .hsync_out(hs_o), .vsync_out(vs_o), .de_out(de_o),
        .h_count_out(h_o), .v_count_out(v_o), .frame_tick(tick_o));

    dvi_pixel_prep #(.HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1), .HW(HW), .VW(VW)) dut_inv (
        .clk_dot4x(clk), .rst_n(rst_n),
        .red_in(red_i), .green_in(green_i), .blue_in(blue_i),
        .hsync_in(hs_i), .vsync_in(vs_i), .active_in(act_i),
`ifdef DVI_TEST_PATTERN_EN
        .tp_en(tp_i),
`endif
        .red_out(i_red), .green_out(i_green), .blue_out(i_blue),
        .hsync_out(i_hs), .vsync_out(i_vs), .de_out(i_de),
        .h_count_out(i_h), .v_count_out(i_v), .frame_tick(i_tick));

    // ---------------- reference model ----------------
    // Works on the stream of samples seen at each rising edge; outputs of sample n are due
    // after edge n+1, so the model keeps one "computed" slot and one "visible" slot.
    typedef struct packed {
        logic [7:0] r, g, b;
        logic hs, vs, de, tick;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
    } out_t;

    logic [23:0] bars [8];
    initial bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                     24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    out_t e_mid = '0, e_out = '0, nx;
    int run = 0, lines = 0, hexp = 0, vexp = 0, idx;
    bit p_act = 0, p_hs = 0, p_vs = 0, tp_lat = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_mid = '0; e_out = '0;
            run = 0; lines = 0; hexp = 0; vexp = 0;
            p_act = 0; p_hs = 0; p_vs = 0; tp_lat = 0;
        end else begin
            e_out   = e_mid;
            nx      = '0;
            nx.hs   = hs_i;
            nx.vs   = vs_i;
            nx.de   = act_i;
            nx.tick = vs_i && !p_vs;
            if (act_i) begin
                idx = p_act ? run : 0;
                if (tp_lat) {nx.r, nx.g, nx.b} = bars[(idx / 32) % 8];
                else begin
                    nx.r = 8'((int'(red_i) * 255) / 63);
                    nx.g = 8'((int'(green_i) * 255) / 63);
                    nx.b = 8'((int'(blue_i) * 255) / 63);
                end
            end
            if (vs_i && !p_vs) begin
                vexp   = lines;
                lines  = (hs_i && !p_hs) ? 1 : 0;
                tp_lat = tp_i;
            end else if (hs_i && !p_hs) begin
                lines = (lines + 1 > VMAX) ? VMAX : lines + 1;
            end
            if (act_i) run = (run + 1 > HMAX) ? HMAX : run + 1;
            else if (p_act) begin
                hexp = run;
                run  = 0;
            end
            nx.h  = HW'(hexp);
            nx.v  = VW'(vexp);
            p_act = act_i; p_hs = hs_i; p_vs = vs_i;
            e_mid = nx;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic check_model();
        check("model", {red_o, green_o, blue_o, hs_o, vs_o, de_o, tick_o, h_o, v_o}, e_out);
        check("inv_sync", {i_hs, i_vs}, {~e_out.hs, ~e_out.vs});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic rand_rgb();
        red_i = 6'($urandom); green_i = 6'($urandom); blue_i = 6'($urandom);
    endtask

    task automatic drive_line(input int alen);
        hs_i = 1'b1; step(1);
        hs_i = 1'b0; step(1);
        act_i = 1'b1;
        repeat (alen) begin rand_rgb(); step(1); end
        act_i = 1'b0; step(1);
    endtask

    typedef struct {
        logic act;
        logic [5:0] r, g, b;
        logic [7:0] er, eg, eb;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 6'd0,  6'd1,  6'd63, 8'd0,   8'd4,   8'd255};
        vecs[1] = '{1'b1, 6'd32, 6'd62, 6'd21, 8'd129, 8'd250, 8'd85};
        vecs[2] = '{1'b1, 6'd42, 6'd10, 6'd50, 8'd170, 8'd40,  8'd202};
        vecs[3] = '{1'b1, 6'd7,  6'd55, 6'd16, 8'd28,  8'd222, 8'd64};
        vecs[4] = '{1'b1, 6'd47, 6'd3,  6'd63, 8'd190, 8'd12,  8'd255};
        vecs[5] = '{1'b0, 6'd63, 6'd63, 6'd63, 8'd0,   8'd0,   8'd0};

        // reset values
        #1;
        check("rst_rgb", {red_o, green_o, blue_o}, 0);
        check("rst_de_tick", {de_o, tick_o}, 0);
        check("rst_counts", {h_o, v_o}, 0);
        check("rst_sync", {hs_o, vs_o}, 2'b00);
        check("rst_sync_inv", {i_hs, i_vs}, 2'b11);
        step(2);
        rst_n = 1'b1;

        // scale table and blanking vectors
        for (int i = 0; i < 6; i++) begin
            act_i = vecs[i].act; red_i = vecs[i].r; green_i = vecs[i].g; blue_i = vecs[i].b;
            step(2);
            check("vec_rgb", {red_o, green_o, blue_o}, {vecs[i].er, vecs[i].eg, vecs[i].eb});
            check("vec_de", de_o, vecs[i].act);
        end

        // full code sweep against the model
        act_i = 1'b1;
        for (int c = 0; c < 64; c++) begin
            red_i = 6'(c); green_i = 6'(63 - c); blue_i = 6'(c ^ 21);
            step(1);
        end
        act_i = 1'b0; red_i = 6'h3F; step(2);
        check("blank_red", {red_o, de_o}, 0);

        // hsync pulse latency and polarity
        hs_i = 1'b1; step(1);
        hs_i = 1'b0; step(1);
        check("hs_lat", {hs_o, i_hs}, 2'b10);
        step(1);
        check("hs_after", {hs_o, i_hs}, 2'b01);

        // 262-line frame, last line 520 active
        vs_i = 1'b1; step(1); vs_i = 1'b0; step(1);
        for (int l = 0; l < 261; l++) drive_line(1);
        drive_line(520);
        vs_i = 1'b1; step(2);
        check("frame_tick", tick_o, 1'b1);
        check("h_520", h_o, 520);
        check("v_262", v_o, 262);
        step(1);
        check("tick_one_cycle", tick_o, 1'b0);
        step(4);
        check("vs_held_no_tick", tick_o, 1'b0);
        vs_i = 1'b0; step(1);

        // vsync and hsync rising together
        vs_i = 1'b1; step(1); vs_i = 1'b0; step(1);
        for (int l = 0; l < 5; l++) drive_line(2);
        vs_i = 1'b1; hs_i = 1'b1; step(2);
        check("vs_hs_same_tick", tick_o, 1'b1);
        check("vs_hs_same_old", v_o, 5);
        vs_i = 1'b0; hs_i = 1'b0; step(1);
        for (int l = 0; l < 3; l++) drive_line(2);
        vs_i = 1'b1; step(2);
        check("vs_hs_next_frame", v_o, 4);
        vs_i = 1'b0; step(1);

        // pixel counter saturation
        act_i = 1'b1;
        repeat (HMAX + 6) begin rand_rgb(); step(1); end
        act_i = 1'b0; step(2);
        check("h_saturate", h_o, HMAX);

        // reset mid-line
        act_i = 1'b1; hs_i = 1'b1; vs_i = 1'b1; step(10);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rgb_de", {red_o, green_o, blue_o, de_o, tick_o}, 0);
        check("midrst_counts", {h_o, v_o}, 0);
        check("midrst_sync", {hs_o, vs_o, i_hs, i_vs}, 4'b0011);
        step(2);
        rst_n = 1'b1; hs_i = 1'b0; vs_i = 1'b0;
        step(5);
        act_i = 1'b0; step(3);

`ifdef DVI_TEST_PATTERN_EN
        // tp_en raised mid-frame only takes effect at the next vsync rise
        vs_i = 1'b1; step(1); vs_i = 1'b0; step(1);
        tp_i = 1'b1; step(1);
        red_i = 6'd21; green_i = 6'd21; blue_i = 6'd21;
        act_i = 1'b1; step(2);
        check("tp_pending", {red_o, green_o, blue_o}, {8'd85, 8'd85, 8'd85});
        step(40); act_i = 1'b0; step(2);
        vs_i = 1'b1; step(1); vs_i = 1'b0; step(2);
        act_i = 1'b1; step(2);
        check("tp_pix0", {red_o, green_o, blue_o}, 24'hFFFFFF);
        step(32);
        check("tp_pix32", {red_o, green_o, blue_o}, 24'hFFFF00);
        act_i = 1'b0; step(2);
        tp_i = 1'b0;
`endif

        // random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rand_rgb();
            if ($urandom_range(19) == 0) act_i = ~act_i;
            if ($urandom_range(7) == 0)  hs_i  = ~hs_i;
            if ($urandom_range(59) == 0) vs_i  = ~vs_i;
            if (TP && $urandom_range(29) == 0) tp_i = ~tp_i;
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
